qerv_dbus_responder: RTL

QERV_DBUS_RESPONDER -- requirements
Module: qerv_dbus_responder

---
 rtl/qerv_dbus_pkg.sv | 11 +
 rtl/qerv_dbus_mem.sv | 44 ++++
 rtl/qerv_dbus_responder.sv | 126 ++++++++++++
 3 files changed

// File: rtl/qerv_dbus_pkg.sv
// Shared encodings for the qerv data-bus responder: FSM states, wait counter width, lane count.
package qerv_dbus_pkg;

    localparam int CNT_W     = 4;
    localparam int NUM_LANES = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;

endpackage

// File: rtl/qerv_dbus_mem.sv
// DEPTH x 32 byte-lane-writable array with one write port and one registered read port.
// The read register clears on reset and holds its value until the next read enable.
module qerv_dbus_mem
    import qerv_dbus_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_we,
    input  logic [NUM_LANES-1:0] i_wsel,
    input  logic [AW-1:0]        i_waddr,
    input  logic [31:0]          i_wdat,
    input  logic                 i_re,
    input  logic [AW-1:0]        i_raddr,
    output logic [31:0]          o_rdat
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdat_q;

    // Array contents are intentionally never reset.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                if (i_wsel[l]) begin
                    mem_q[i_waddr][8*l +: 8] <= i_wdat[8*l +: 8];
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rdat_q <= '0;
        end else if (i_re) begin
            rdat_q <= mem_q[i_raddr];
        end
    end

    assign o_rdat = rdat_q;

endmodule

// File: rtl/qerv_dbus_responder.sv
// Wishbone-style data-bus responder with fixed latency: ack 1+WAIT_CYCLES cycles after cyc is sampled.
// Wait states exist only when QERV_DBUS_WAIT_EN is defined; otherwise latency is always 1.
module qerv_dbus_responder
    import qerv_dbus_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_wb_adr,
    input  logic [31:0] i_wb_dat,
    input  logic [3:0]  i_wb_sel,
    input  logic        i_wb_we,
    input  logic        i_wb_cyc,
    output logic [31:0] o_wb_rdt,
    output logic        o_wb_ack
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES);

    logic [1:0]           state_q, state_d;
    logic [AW-1:0]        adr_q, adr_d;
    logic [31:0]          dat_q, dat_d;
    logic [NUM_LANES-1:0] sel_q, sel_d;
    logic                 we_q, we_d;
    logic                 mem_we, mem_re;
    logic                 unused_ok;

`ifdef QERV_DBUS_WAIT_EN
    logic [CNT_W-1:0]     cnt_q, cnt_d;
`endif

    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        we_d    = we_q;
`ifdef QERV_DBUS_WAIT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (i_wb_cyc) begin
                    adr_d = i_wb_adr[AW+1:2];
                    dat_d = i_wb_dat;
                    sel_d = i_wb_sel;
                    we_d  = i_wb_we;
`ifdef QERV_DBUS_WAIT_EN
                    cnt_d = WAIT_LOAD;
                    state_d = (WAIT_LOAD == '0) ? ST_ACK : ST_WAIT;
`else
                    state_d = ST_ACK;
`endif
                end
            end
`ifdef QERV_DBUS_WAIT_EN
            ST_WAIT: begin
                // Initiator withdrawing cyc abandons the access before anything commits.
                if (!i_wb_cyc) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_ACK;
                    end
                end
            end
`endif
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Read data is captured on the edge entering ACK, using the address/we being latched on that edge.
    assign mem_re   = (state_d == ST_ACK) && (state_q != ST_ACK) && !we_d && !i_rst;
    assign mem_we   = (state_q == ST_ACK) && we_q && !i_rst;
    assign o_wb_ack = (state_q == ST_ACK);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef QERV_DBUS_WAIT_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    always_ff @(posedge i_clk) begin
        adr_q <= adr_d;
        dat_q <= dat_d;
        sel_q <= sel_d;
        we_q  <= we_d;
    end

    qerv_dbus_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_we    (mem_we),
        .i_wsel  (sel_q),
        .i_waddr (adr_q),
        .i_wdat  (dat_q),
        .i_re    (mem_re),
        .i_raddr (adr_d),
        .o_rdat  (o_wb_rdt)
    );

    // Upper and byte-offset address bits alias by design.
    assign unused_ok = ^{i_wb_adr[31:AW+2], i_wb_adr[1:0], WAIT_LOAD};

endmodule
